// File: rtl/keypad_scanner_if.sv
// Key event bundle from the keypad scanner to the OTP entry FSM.
// Signals: key_code (4b last accepted key), key_valid (1-cycle strobe), key_held.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    input key_code,
    input key_valid,
    input key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce, one strobe per press.
// Ports: clk, reset (async active-low), row_in[3:0] (active-low rows),
//   col_out[3:0] (active-low drive, one bit low), key (master: key_code,
//   key_valid, key_held).
// Macro KEYPAD_DIGIT_ONLY_EN: keys A-D, *, # debounce and hold but never strobe.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  keypad_scanner_if.master key
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_d;
  logic [CW-1:0] deb_q;
  logic [CW-1:0] deb_d;
  logic [1:0]    col_q;
  logic [1:0]    col_d;
  logic [1:0]    row_q;
  logic [1:0]    row_d;
  logic [3:0]    code_q;
  logic [3:0]    code_d;
  logic          valid_q;
  logic          valid_d;
  logic          held_q;
  logic          held_d;

  logic [3:0]    rs_meta;
  logic [3:0]    rs;
  logic [3:0]    inv;
  logic          hot;
  logic          all_up;
  logic          match;
  logic [1:0]    hot_row;
  logic [3:0]    lut_code;
  logic          strobe_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_meta <= 4'hF;
      rs      <= 4'hF;
    end else begin
      rs_meta <= row_in;
      rs      <= rs_meta;
    end
  end

  function automatic logic [3:0] key_lut(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    unique case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  // A single low row is a clean press; zero or several low rows are not.
  assign inv    = ~rs;
  assign hot    = (inv != 4'h0) && ((inv & (inv - 4'd1)) == 4'h0);
  assign all_up = (rs == 4'hF);
  assign match  = (rs == ~(4'b0001 << row_q));

  assign lut_code = key_lut(row_q, col_q);

`ifdef KEYPAD_DIGIT_ONLY_EN
  assign strobe_ok = (lut_code <= 4'd9);
`else
  assign strobe_ok = 1'b1;
`endif

  // Decoder only evaluated when inv is known one-hot.
  always_comb begin
    hot_row = 2'd0;
    if (hot) begin
      unique case (1'b1)
        inv[0]:  hot_row = 2'd0;
        inv[1]:  hot_row = 2'd1;
        inv[2]:  hot_row = 2'd2;
        inv[3]:  hot_row = 2'd3;
        default: hot_row = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN;
      dwell_q <= '0;
      deb_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      deb_q   <= deb_d;
      col_q   <= col_d;
      row_q   <= row_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    deb_d   = deb_q;
    col_d   = col_q;
    row_d   = row_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;

    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (hot) begin
            state_d = DEBOUNCE;
            deb_d   = '0;
            row_d   = hot_row;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (!match) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          deb_d   = '0;
          held_d  = 1'b1;
          if (strobe_ok) begin
            code_d  = lut_code;
            valid_d = 1'b1;
          end
        end else begin
          deb_d = deb_q + CW'(1);
        end
      end

      PRESSED: begin
        if (all_up) begin
          state_d = RELEASE;
          deb_d   = '0;
        end
      end

      RELEASE: begin
        if (!all_up) begin
          state_d = PRESSED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = SCAN;
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + CW'(1);
        end
      end

      default: begin
        state_d = SCAN;
        dwell_d = '0;
        deb_d   = '0;
      end
    endcase
  end

  assign col_out       = ~(4'b0001 << col_q);
  assign key.key_code  = code_q;
  assign key.key_valid = valid_q;
  assign key.key_held  = held_q;

endmodule
